// File: rtl/ladybird_lsu.sv
// Load/store unit between execute and memory access. Accepts one RV32 load or
// store at a time, checks alignment, issues a word-aligned memory request with
// byte strobes and replicated store data, extends the returned load lane, and
// hands the result (or a misalignment fault) to writeback.
module ladybird_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            anrst,
  input  logic            nrst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic [4:0]      req_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_rvalid,
  output logic            mem_rready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              op_store_q, op_store_d;
  logic [2:0]        op_funct3_q, op_funct3_d;
  logic [1:0]        op_lane_q, op_lane_d;
  logic [4:0]        op_rd_q, op_rd_d;

  logic              req_ready_q, req_ready_d;
  logic              mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_data_q, mem_data_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              mem_rready_q, mem_rready_d;
  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_fault_q, wb_fault_d;

  logic              acc_fault;
  logic [3:0]        acc_strb;
  logic [XLEN-1:0]   acc_wdata;
  logic [XLEN-1:0]   rdata_shift;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [XLEN-1:0]   load_val;

  // Decode the offered operation: fault check, strobes and replicated data.
  always_comb begin
    acc_fault = 1'b0;
    acc_strb  = 4'b0000;
    acc_wdata = '0;
    // funct3 3, 6 and 7 are not loads/stores; unsigned variants have no store form.
    if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) acc_fault = 1'b1;
    if (req_store && req_funct3 > 3'd2) acc_fault = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) acc_fault = 1'b1;
    if (req_funct3 == 3'd2 && req_addr[1:0] != 2'b00) acc_fault = 1'b1;
    if (req_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          acc_strb  = 4'b0001 << req_addr[1:0];
          acc_wdata = {4{req_data[7:0]}};
        end
        2'b01: begin
          acc_strb  = 4'b0011 << req_addr[1:0];
          acc_wdata = {2{req_data[15:0]}};
        end
        default: begin
          acc_strb  = 4'b1111;
          acc_wdata = req_data;
        end
      endcase
    end
  end

  // Pick the addressed lane of the returned word and extend it.
  always_comb begin
    rdata_shift = mem_rdata >> {op_lane_q, 3'b000};
    lane_b      = rdata_shift[7:0];
    lane_h      = op_lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_funct3_q)
      3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
      3'd4:    load_val = {24'd0, lane_b};
      3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
      3'd5:    load_val = {16'd0, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic; synchronous reset applied last.
  always_comb begin
    state_d      = state_q;
    op_store_d   = op_store_q;
    op_funct3_d  = op_funct3_q;
    op_lane_d    = op_lane_q;
    op_rd_d      = op_rd_q;
    req_ready_d  = req_ready_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_rready_d = mem_rready_q;
    wb_valid_d   = wb_valid_q;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_fault_d   = wb_fault_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_store_d  = req_store;
          op_funct3_d = req_funct3;
          op_lane_d   = req_addr[1:0];
          op_rd_d     = req_rd;
          req_ready_d = 1'b0;
          if (acc_fault) begin
            state_d    = StResp;
            wb_valid_d = 1'b1;
            wb_data_d  = req_addr;
            wb_rd_d    = 5'd0;
            wb_fault_d = 1'b1;
          end else begin
            state_d     = StReq;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wstrb_d = acc_strb;
            mem_data_d  = acc_wdata;
          end
        end
      end
      StReq: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (op_store_q) begin
            state_d    = StResp;
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            wb_rd_d    = 5'd0;
            wb_fault_d = 1'b0;
          end else begin
            state_d      = StWait;
            mem_rready_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d      = StResp;
          mem_rready_d = 1'b0;
          wb_valid_d   = 1'b1;
          wb_data_d    = load_val;
          wb_rd_d      = op_rd_q;
          wb_fault_d   = 1'b0;
        end
      end
      StResp: begin
        if (wb_ready) begin
          state_d     = StIdle;
          wb_valid_d  = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!nrst) begin
      state_d      = StIdle;
      op_store_d   = 1'b0;
      op_funct3_d  = 3'd0;
      op_lane_d    = 2'd0;
      op_rd_d      = 5'd0;
      req_ready_d  = 1'b1;
      mem_valid_d  = 1'b0;
      mem_addr_d   = '0;
      mem_data_d   = '0;
      mem_wstrb_d  = 4'd0;
      mem_rready_d = 1'b0;
      wb_valid_d   = 1'b0;
      wb_data_d    = '0;
      wb_rd_d      = 5'd0;
      wb_fault_d   = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q      <= StIdle;
      op_store_q   <= 1'b0;
      op_funct3_q  <= 3'd0;
      op_lane_q    <= 2'd0;
      op_rd_q      <= 5'd0;
      req_ready_q  <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wstrb_q  <= 4'd0;
      mem_rready_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= 5'd0;
      wb_fault_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_store_q   <= op_store_d;
      op_funct3_q  <= op_funct3_d;
      op_lane_q    <= op_lane_d;
      op_rd_q      <= op_rd_d;
      req_ready_q  <= req_ready_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_rready_q <= mem_rready_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_fault_q   <= wb_fault_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_rready = mem_rready_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign wb_fault   = wb_fault_q;

endmodule

// File: tb/tb_ladybird_lsu.sv
// Scoreboard bench for ladybird_lsu: stimulus pushes expected memory requests and
// writeback results; a negedge monitor compares whatever the DUT presents.
module tb_ladybird_lsu;

  logic        clk, anrst, nrst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_data;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_rvalid, mem_rready;
  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_ready, wb_fault;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
  } wb_exp_t;

  mem_exp_t mem_q[$];
  wb_exp_t  wb_q[$];

  ladybird_lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .anrst      (anrst),
    .nrst       (nrst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_fault   (wb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare presented outputs against the queue heads every cycle, so
  // stalled fields must stay equal to the expected values; pop on handshake.
  always @(negedge clk) begin
    if (anrst && nrst) begin
      if (mem_valid) begin
        if (mem_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_unexpected: got mem_valid=1 addr %h expected no request", mem_addr);
        end else begin
          check("mem_addr", mem_addr, mem_q[0].addr);
          check("mem_data", mem_data, mem_q[0].data);
          check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, mem_q[0].wstrb});
          if (mem_ready) void'(mem_q.pop_front());
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wb_unexpected: got wb_valid=1 data %h expected no result", wb_data);
        end else begin
          check("wb_data", wb_data, wb_q[0].data);
          check("wb_rd", {27'd0, wb_rd}, {27'd0, wb_q[0].rd});
          check("wb_fault", {31'd0, wb_fault}, {31'd0, wb_q[0].fault});
          if (wb_ready) void'(wb_q.pop_front());
        end
      end
    end
  end

  task automatic push_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_exp_t e;
    e.addr = a; e.data = d; e.wstrb = s;
    mem_q.push_back(e);
  endtask

  task automatic push_wb(input logic [31:0] d, input logic [4:0] rd, input logic f);
    wb_exp_t e;
    e.data = d; e.rd = rd; e.fault = f;
    wb_q.push_back(e);
  endtask

  // Offer one operation; returns at accept edge + 1.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    req_store = st; req_funct3 = f3; req_addr = a; req_data = d; req_rd = rd;
    req_valid = 1'b1;
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("req_ready_after_accept", {31'd0, req_ready}, 32'd0);
  endtask

  // Accept the result after wstall cycles, then check the return to idle.
  task automatic finish_wb(input int wstall);
    int n;
    repeat (wstall) begin @(posedge clk); #1; end
    wb_ready = 1'b1;
    n = 0;
    while (!wb_valid && n < 30) begin @(posedge clk); #1; n++; end
    if (n == 30) begin
      tests++; fails++;
      $display("FAIL wb_timeout: got no wb_valid expected wb_valid within 30 cycles");
    end
    @(posedge clk); #1;
    wb_ready = 1'b0;
    check("wb_valid_after_hs", {31'd0, wb_valid}, 32'd0);
    check("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic serve(input int mstall, input bit is_load, input logic [31:0] rdata,
                       input int rdelay, input int wstall);
    repeat (mstall) begin @(posedge clk); #1; end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (is_load) begin
      check("mem_rready_in_wait", {31'd0, mem_rready}, 32'd1);
      repeat (rdelay) begin @(posedge clk); #1; end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
    end
    finish_wb(wstall);
  endtask

  // Count cycles from the accept edge until wb_valid is seen.
  task automatic latency(output int n);
    n = 1;
    while (!wb_valid && n < 30) begin @(posedge clk); #1; n++; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
    check({tag, "_mem_rready"}, {31'd0, mem_rready}, 32'd0);
    check({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_data"}, mem_data, 32'd0);
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    check({tag, "_wb_fault"}, {31'd0, wb_fault}, 32'd0);
  endtask

  initial begin
    int n;
    anrst = 1'b1; nrst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_data = '0; req_rd = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555; wb_ready = 1'b0;
    #1 anrst = 1'b0;
    #2 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 anrst = 1'b1;
    @(posedge clk); #1;

    // LB at 0x1003, minimum latency with memory always ready.
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    push_mem(32'h1000, 32'h0, 4'b0000);
    push_wb(32'hFFFF_FF80, 5'd7, 1'b0);
    issue(1'b0, 3'd0, 32'h1003, 32'h0, 5'd7);
    latency(n);
    check("lb_latency", n, 32'd3);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    finish_wb(0);

    // LBU same address.
    push_mem(32'h1000, 32'h0, 4'b0000);
    push_wb(32'h0000_0080, 5'd8, 1'b0);
    issue(1'b0, 3'd4, 32'h1003, 32'h0, 5'd8);
    serve(0, 1'b1, 32'h80FF_1234, 0, 0);

    // SH at 0x2002, minimum store latency.
    mem_ready = 1'b1;
    push_mem(32'h2000, 32'hABCD_ABCD, 4'b1100);
    push_wb(32'h0, 5'd0, 1'b0);
    issue(1'b1, 3'd1, 32'h2002, 32'h0000_ABCD, 5'd12);
    latency(n);
    check("sh_latency", n, 32'd2);
    mem_ready = 1'b0;
    finish_wb(0);

    // Misaligned LW: fault one cycle after accept, no memory request.
    push_wb(32'h3001, 5'd0, 1'b1);
    issue(1'b0, 3'd2, 32'h3001, 32'h0, 5'd5);
    latency(n);
    check("fault_latency", n, 32'd1);
    check("fault_no_mem_valid", {31'd0, mem_valid}, 32'd0);
    finish_wb(0);

    // Stalled LW: mem_ready low 4, rvalid 3 late, wb_ready low 2.
    push_mem(32'h4000, 32'h0, 4'b0000);
    push_wb(32'hDEAD_BEEF, 5'd9, 1'b0);
    issue(1'b0, 3'd2, 32'h4000, 32'h0, 5'd9);
    serve(4, 1'b1, 32'hDEAD_BEEF, 3, 2);

    // Stray rvalid in IDLE and REQ, then LH of upper half.
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    push_mem(32'h5000, 32'h0, 4'b0000);
    push_wb(32'hFFFF_8001, 5'd10, 1'b0);
    issue(1'b0, 3'd1, 32'h5002, 32'h0, 5'd10);
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    serve(1, 1'b1, 32'h8001_7FFF, 0, 0);

    // LHU same word.
    push_mem(32'h5000, 32'h0, 4'b0000);
    push_wb(32'h0000_8001, 5'd11, 1'b0);
    issue(1'b0, 3'd5, 32'h5002, 32'h0, 5'd11);
    serve(0, 1'b1, 32'h8001_7FFF, 1, 0);

    // SB at 0x6001.
    push_mem(32'h6000, 32'hA5A5_A5A5, 4'b0010);
    push_wb(32'h0, 5'd0, 1'b0);
    issue(1'b1, 3'd0, 32'h6001, 32'h1234_56A5, 5'd3);
    serve(0, 1'b0, 32'h0, 0, 1);

    // Illegal funct3 load and unsigned-store faults.
    push_wb(32'h7000, 5'd0, 1'b1);
    issue(1'b0, 3'd3, 32'h7000, 32'h0, 5'd4);
    finish_wb(0);
    push_wb(32'h7004, 5'd0, 1'b1);
    issue(1'b1, 3'd4, 32'h7004, 32'h0, 5'd4);
    finish_wb(0);

    // Synchronous reset while in WAIT; the late rvalid must be dropped.
    push_mem(32'h8000, 32'h0, 4'b0000);
    issue(1'b0, 3'd2, 32'h8000, 32'h0, 5'd3);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("rst_in_wait_rready", {31'd0, mem_rready}, 32'd1);
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    check_reset_outputs("sync_reset");
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("late_rvalid_ignored", {31'd0, wb_valid}, 32'd0);

    // SW at 0x10 after reset.
    push_mem(32'h10, 32'hCAFE_F00D, 4'b1111);
    push_wb(32'h0, 5'd0, 1'b0);
    issue(1'b1, 3'd2, 32'h10, 32'hCAFE_F00D, 5'd1);
    serve(0, 1'b0, 32'h0, 0, 0);

    repeat (2) @(posedge clk);
    check("mem_queue_drained", mem_q.size(), 32'd0);
    check("wb_queue_drained", wb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
